// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT peak detector.
// FFT_PEAK_ENERGY_EN adds a frame-energy field to the result struct.
package fft_pkg;

  localparam int MAG_W       = 21;
  localparam int FFT_LEN_DEF = 1024;
  // Widest bin index the result struct can carry (FFT_LEN up to 65536).
  localparam int BIN_W_MAX   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } peak_state_t;

  typedef struct packed {
    logic [MAG_W-1:0]           mag;
    logic [BIN_W_MAX-1:0]       bin;
`ifdef FFT_PEAK_ENERGY_EN
    logic [MAG_W+BIN_W_MAX-1:0] energy;
`endif
  } peak_result_t;

endpackage

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over streamed FFT magnitudes with a valid/ready result register.
// Optional FFT_PEAK_ENERGY_EN adds the frame_energy output (sum of searched bins).
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int FFT_LEN    = FFT_LEN_DEF,
  parameter int SEARCH_LEN = 512,
  parameter int SKIP_DC    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MAG_W-1:0]           mag_in,
  input  logic                       mag_valid,
  input  logic                       mag_sop,
  output logic [MAG_W-1:0]           peak_mag,
  output logic [$clog2(FFT_LEN)-1:0] peak_bin,
  output logic                       peak_valid,
  input  logic                       peak_ready,
  output logic                       sync_err,
`ifdef FFT_PEAK_ENERGY_EN
  output logic [MAG_W+$clog2(FFT_LEN)-1:0] frame_energy,
`endif
  output logic                       overrun
);

  localparam int BIN_W    = $clog2(FFT_LEN);
  localparam int ENERGY_W = MAG_W + BIN_W;
  localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(FFT_LEN - 1);
  localparam logic [BIN_W:0]   SEARCH_LIM = (BIN_W+1)'(SEARCH_LEN);
  // With DC skipped, an all-zero frame reports the first searched bin.
  localparam logic [BIN_W-1:0] INIT_IDX   = (SKIP_DC != 0) ? BIN_W'(1) : '0;

  peak_state_t      state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic [MAG_W-1:0] max_q, max_d;
  peak_result_t     res_q, res_d, cur;
  logic             peak_valid_q, peak_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             overrun_q, overrun_d;
`ifdef FFT_PEAK_ENERGY_EN
  logic [ENERGY_W-1:0] energy_q, energy_d, base_en;
`endif

  logic             start, take, searched;
  logic [BIN_W-1:0] bin, base_idx;
  logic [MAG_W-1:0] base_max;

  always_comb begin
    cur     = '0;
    cur.mag = max_q;
    cur.bin = BIN_W_MAX'(idx_q);
`ifdef FFT_PEAK_ENERGY_EN
    cur.energy = (MAG_W+BIN_W_MAX)'(energy_q);
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    max_d        = max_q;
    res_d        = res_q;
    peak_valid_d = peak_valid_q & ~peak_ready;
    sync_err_d   = 1'b0;
    overrun_d    = overrun_q;
    start        = 1'b0;
    take         = 1'b0;
    bin          = '0;
    base_idx     = '0;
    base_max     = '0;
    searched     = 1'b0;
`ifdef FFT_PEAK_ENERGY_EN
    energy_d     = energy_q;
    base_en      = '0;
`endif

    case (state_q)
      IDLE: begin
        if (mag_valid && mag_sop) begin
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (mag_valid) begin
          take = 1'b1;
          if (mag_sop) begin
            start      = 1'b1;
            sync_err_d = 1'b1;
          end else if (cnt_q == LAST_BIN) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!peak_valid_q || peak_ready) begin
          res_d        = cur;
          peak_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        // A new frame may start right here so back-to-back frames lose no beat.
        if (mag_valid && mag_sop) begin
          start   = 1'b1;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start || take) begin
      bin      = start ? '0 : cnt_q;
      base_max = start ? '0 : max_q;
      base_idx = start ? INIT_IDX : idx_q;
      searched = ({1'b0, bin} < SEARCH_LIM) && !((SKIP_DC != 0) && (bin == '0));
      if (searched && (mag_in > base_max)) begin
        max_d = mag_in;
        idx_d = bin;
      end else begin
        max_d = base_max;
        idx_d = base_idx;
      end
`ifdef FFT_PEAK_ENERGY_EN
      base_en  = start ? '0 : energy_q;
      energy_d = base_en + (searched ? ENERGY_W'(mag_in) : '0);
`endif
      cnt_d = (bin == LAST_BIN) ? '0 : bin + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      max_q        <= '0;
      res_q        <= '0;
      peak_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FFT_PEAK_ENERGY_EN
      energy_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      max_q        <= max_d;
      res_q        <= res_d;
      peak_valid_q <= peak_valid_d;
      sync_err_q   <= sync_err_d;
      overrun_q    <= overrun_d;
`ifdef FFT_PEAK_ENERGY_EN
      energy_q     <= energy_d;
`endif
    end
  end

  assign peak_mag   = res_q.mag;
  assign peak_bin   = res_q.bin[BIN_W-1:0];
  assign peak_valid = peak_valid_q;
  assign sync_err   = sync_err_q;
  assign overrun    = overrun_q;
`ifdef FFT_PEAK_ENERGY_EN
  assign frame_energy = res_q.energy[ENERGY_W-1:0];
`endif

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector: two instances (DC skipped / DC searched)
// share one magnitude stream; a reference model predicts each reported frame.
module tb_fft_peak_detector;

  localparam int FFT = 16;
  localparam int SL  = 8;
  localparam int BW  = $clog2(FFT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [20:0] mag_in = '0;
  logic mag_valid = 1'b0;
  logic mag_sop = 1'b0;
  logic peak_ready = 1'b1;

  logic [20:0] pm1, pm0;
  logic [BW-1:0] pb1, pb0;
  logic pv1, pv0, se1, se0, ov1, ov0;
`ifdef FFT_PEAK_ENERGY_EN
  logic [20+BW:0] fe1, fe0;
`endif

  always #5 clk = ~clk;

  fft_peak_detector #(.FFT_LEN(FFT), .SEARCH_LEN(SL), .SKIP_DC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .mag_valid(mag_valid), .mag_sop(mag_sop),
    .peak_mag(pm1), .peak_bin(pb1), .peak_valid(pv1), .peak_ready(peak_ready),
    .sync_err(se1),
`ifdef FFT_PEAK_ENERGY_EN
    .frame_energy(fe1),
`endif
    .overrun(ov1));

  fft_peak_detector #(.FFT_LEN(FFT), .SEARCH_LEN(SL), .SKIP_DC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .mag_valid(mag_valid), .mag_sop(mag_sop),
    .peak_mag(pm0), .peak_bin(pb0), .peak_valid(pv0), .peak_ready(peak_ready),
    .sync_err(se0),
`ifdef FFT_PEAK_ENERGY_EN
    .frame_energy(fe0),
`endif
    .overrun(ov0));

  typedef struct {
    int unsigned     mag;
    int unsigned     bin;
    longint unsigned en;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: first index holding the largest searched value; energy = plain sum.
  function automatic exp_t model(input int unsigned v[FFT], input bit skip);
    exp_t r;
    bit found = 0;
    r.mag = 0;
    r.bin = skip ? 1 : 0;
    r.en  = 0;
    for (int b = 0; b < SL; b++) begin
      if (skip && b == 0) continue;
      r.en += v[b];
      if (!found || v[b] > r.mag) begin
        r.mag = v[b];
        r.bin = b;
        found = 1;
      end
    end
    return r;
  endfunction

  task automatic expect_frame(input int unsigned v[FFT]);
    q1.push_back(model(v, 1'b1));
    q0.push_back(model(v, 1'b0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pv1 && peak_ready) begin
      if (q1.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL dut1_unexpected: got result %0d@%0d, expected none", pm1, pb1);
      end else begin
        e = q1.pop_front();
        check("dut1_mag", 64'(pm1), 64'(e.mag));
        check("dut1_bin", 64'(pb1), 64'(e.bin));
`ifdef FFT_PEAK_ENERGY_EN
        check("dut1_energy", 64'(fe1), 64'(e.en));
`endif
      end
    end
    if (rst_n && pv0 && peak_ready) begin
      if (q0.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL dut0_unexpected: got result %0d@%0d, expected none", pm0, pb0);
      end else begin
        e = q0.pop_front();
        check("dut0_mag", 64'(pm0), 64'(e.mag));
        check("dut0_bin", 64'(pb0), 64'(e.bin));
`ifdef FFT_PEAK_ENERGY_EN
        check("dut0_energy", 64'(fe0), 64'(e.en));
`endif
      end
    end
  end

  task automatic drive_beat(input bit v, input bit s, input int unsigned m);
    mag_valid = v;
    mag_sop   = s;
    mag_in    = 21'(m);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, $urandom);
  endtask

  task automatic send_frame(input int unsigned v[FFT], input bit gaps);
    for (int b = 0; b < FFT; b++) begin
      if (gaps) idle($urandom_range(0, 2));
      drive_beat(1'b1, b == 0, v[b]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mag1"}, 64'(pm1), 0);
    check({tag, "_bin1"}, 64'(pb1), 0);
    check({tag, "_valid1"}, 64'(pv1), 0);
    check({tag, "_syncerr1"}, 64'(se1), 0);
    check({tag, "_overrun1"}, 64'(ov1), 0);
    check({tag, "_valid0"}, 64'(pv0), 0);
    check({tag, "_overrun0"}, 64'(ov0), 0);
  endtask

  int unsigned fr[FFT];
  int unsigned fa[FFT];

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Basic ramp and latency
    for (int b = 0; b < FFT; b++) fr[b] = b;
    expect_frame(fr);
    send_frame(fr, 1'b0);
    check("latency_n1", 64'(pv1), 0);
    idle(1);
    check("latency_n2", 64'(pv1), 1);
    idle(3);

    // Ties and DC skip
    for (int b = 0; b < FFT; b++) fr[b] = 10;
    fr[0] = 900; fr[3] = 500; fr[5] = 500;
    expect_frame(fr);
    send_frame(fr, 1'b0);
    idle(4);

    // Backpressure and overrun: only the first frame is ever reported
    peak_ready = 1'b0;
    for (int b = 0; b < FFT; b++) begin fr[b] = 1; fa[b] = 1; end
    fr[2] = 100; fa[5] = 200;
    expect_frame(fr);
    send_frame(fr, 1'b0);
    send_frame(fa, 1'b0);
    idle(4);
    check("held_mag1", 64'(pm1), 100);
    check("held_valid1", 64'(pv1), 1);
    check("overrun1", 64'(ov1), 1);
    check("held_mag0", 64'(pm0), 100);
    check("overrun0", 64'(ov0), 1);
    peak_ready = 1'b1;
    idle(1);
    peak_ready = 1'b0;
    check("released_valid1", 64'(pv1), 0);
    check("released_valid0", 64'(pv0), 0);
    peak_ready = 1'b1;
    idle(2);

    // Mid-frame resync at bin 6
    for (int b = 0; b < 6; b++) drive_beat(1'b1, b == 0, (b == 3) ? 5000 : 2);
    for (int b = 0; b < FFT; b++) fr[b] = $urandom_range(0, 300);
    expect_frame(fr);
    for (int b = 0; b < FFT; b++) begin
      drive_beat(1'b1, b == 0, fr[b]);
      if (b == 0) check("sync_err_pulse", 64'(se1), 1);
      if (b == 1) check("sync_err_clear", 64'(se1), 0);
    end
    idle(4);

    // Gapped valid with full-scale peak at bin 4
    for (int b = 0; b < FFT; b++) fr[b] = $urandom_range(0, 20'hFFFFF);
    fr[4] = 21'h1FFFFF;
    expect_frame(fr);
    send_frame(fr, 1'b1);
    idle(4);

    // Random frames: narrow ranges for ties, wide ranges, all-zero, back-to-back
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < FFT; b++)
        fr[b] = (k == 5) ? 0 : (k % 2) ? $urandom_range(0, 7) : ($urandom & 32'h1FFFFF);
      expect_frame(fr);
      send_frame(fr, k % 3 == 0);
    end
    idle(4);

    // Reset at bin 9 of a frame
    for (int b = 0; b < 9; b++) drive_beat(1'b1, b == 0, 1000 + b);
    mag_valid = 1'b1; mag_sop = 1'b0; mag_in = 21'd7;
    peak_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    peak_ready = 1'b1;
    for (int b = 0; b < 20; b++) drive_beat(1'b1, 1'b0, 21'h1FFFFF);
    idle(3);
    check("nosop_ignored", 64'(pv1), 0);
    for (int b = 0; b < FFT; b++) fr[b] = $urandom_range(0, 1000);
    expect_frame(fr);
    send_frame(fr, 1'b0);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && (q1.size() != 0 || q0.size() != 0); i++) idle(1);
    check("drain_q1", 64'(q1.size()), 0);
    check("drain_q0", 64'(q0.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Streaming peak search placed directly downstream of the FFT magnitude stage. Consumes one 21-bit unsigned magnitude per valid cycle, counts bins within each FFT frame, and reports the largest magnitude and its bin index once per frame. The result is held in an output register behind a valid/ready handshake until the consumer, typically the frequency-estimation or host-readout logic, accepts it.

## Interface
- `FFT_LEN`, 1024: bins per frame; must be a power of two, ≥ 4.
- `SEARCH_LEN`, 512: bins `0..SEARCH_LEN-1` are searched, remaining bins are counted but ignored; 1 ≤ `SEARCH_LEN` ≤ `FFT_LEN`.
- `SKIP_DC`, 1: when 1, bin 0 is excluded from the search.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `mag_in` in 21: unsigned magnitude from the magnitude stage.
- `mag_valid` in 1: `mag_in` is a valid bin this cycle.
- `mag_sop` in 1: qualifies `mag_valid`; marks bin 0 of a frame.
- `peak_mag` out 21: largest magnitude of the last completed frame.
- `peak_bin` out `$clog2(FFT_LEN)`: bin index of `peak_mag`.
- `peak_valid` out 1: result register holds an unaccepted result.
- `peak_ready` in 1: consumer accepts the result when high with `peak_valid`.
- `sync_err` out 1: one-cycle pulse on an `mag_sop` arriving mid-frame.
- `overrun` out 1: sticky; a frame completed while the previous result was still unaccepted.

## Operation
- FSM states are IDLE, ACCUM and FLUSH.
- IDLE: ignores `mag_valid` without `mag_sop`. A `mag_valid & mag_sop` moves to ACCUM, with that beat as bin 0.
- ACCUM: the bin counter increments on every `mag_valid`. The running maximum updates when the bin is in range and `mag_in > max` (strict). On ties the lowest index wins.
- Running maximum initialises to 0 and index 0 at bin 0. If `SKIP_DC`=1 and every searched bin is 0, the result is `peak_mag`=0, `peak_bin`=1.
- The beat with counter = `FFT_LEN-1` completes the frame. The FSM goes to FLUSH for one cycle, which loads the result register, then returns to IDLE.
- `mag_sop` while in ACCUM: the current frame is discarded and `sync_err` pulses for one cycle. The beat is taken as bin 0 of a new frame, and the state stays ACCUM.
- `mag_sop` on the same beat as frame completion (bin `FFT_LEN-1`) is a sync error handled as above; the completing frame is not reported.
- Result load in FLUSH:
  - If `peak_valid`=0, or `peak_valid & peak_ready` in the same cycle, the new result is loaded and `peak_valid`=1.
  - Otherwise the new result is dropped, the old result is kept, and `overrun` is set.
- Back-to-back frames are supported: a `mag_valid & mag_sop` during FLUSH starts the next frame with no lost beat. The FLUSH→IDLE transition is overridden to ACCUM.
- `rst_n` low mid-frame discards all state immediately.

## Timing
- Reset values: `peak_mag`=0, `peak_bin`=0, `peak_valid`=0, `sync_err`=0, `overrun`=0, FSM=IDLE, counter=0.
- Latency: last bin accepted at cycle N puts the result on outputs with `peak_valid`=1 at cycle N+2. This is one cycle for the compare register and one cycle for FLUSH.
- `peak_valid` deasserts the cycle after `peak_valid & peak_ready`.
- Outputs hold stable while `peak_valid & !peak_ready`.
- No backpressure toward the magnitude stage: a bin is accepted every cycle `mag_valid`=1.

## Configuration
- `FFT_PEAK_ENERGY_EN` defined:
  - Adds output `frame_energy`, width 21+`$clog2(FFT_LEN)`, reset 0.
  - It is the sum of all searched bins, honouring `SKIP_DC`, with no saturation needed at that width.
  - It is loaded and held together with `peak_mag` under the same handshake.
- `FFT_PEAK_ENERGY_EN` undefined: the port and the accumulator do not exist.

## Structure
- Shared package `fft_pkg`:
  - `MAG_W`=21.
  - Default `FFT_LEN`.
  - FSM state enum type `peak_state_t`.
  - A `peak_result_t` struct holding mag, bin and, under the macro, energy.
- Single module; no sub-module is warranted. The bin counter and compare logic stay inline.

## Test plan
- **Basic peak:** `FFT_LEN`=16, `SEARCH_LEN`=8, ramp 0..15, `peak_ready`=1. Expect `peak_mag`=7, `peak_bin`=7, `peak_valid` 2 cycles after bin 15.
- **Tie and DC skip:** bin 0=900, bins 3 and 5=500, others 10. With `SKIP_DC`=1, expect 500 @ bin 3. With `SKIP_DC`=0, expect 900 @ bin 0.
- **Backpressure/overrun:** two back-to-back frames with peaks 100 and 200, `peak_ready`=0. Expect 100 held, `overrun`=1; after `peak_ready` pulses, `peak_valid`=0.
- **Mid-frame resync:** `mag_sop` at bin 6 of a 16-bin frame. Expect a one-cycle `sync_err` and a result covering only the new frame.
- **Gapped valid:** random `mag_valid` gaps and a frame with peak 0x1FFFFF at bin 4. Expect 0x1FFFFF @ 4; with `FFT_PEAK_ENERGY_EN`, `frame_energy` equals the exact sum of the searched bins.
- **Reset mid-frame:** `rst_n` low at bin 9. Expect all outputs 0 and `valid` ignored until the next `mag_sop`.
